div_unit: RTL and testbench

- Multi-cycle integer divider. It is the responder end of the EX-stage long-latency handshake: EX drives `start` and holds its stall until `result_ok`.
- It serves DIV/DIVU and delivers {remainder, quotient} for the hilo register: hi = remainder, lo = quotient.
- It sits beside the multiplier in EX and uses the same start / result_ok protocol.

---
 rtl/div_unit_pkg.sv | 31 +++
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit_step.sv | 27 ++
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage integer divider: FSM encoding, latency
// helper and the EX opcodes that select a divide.
package div_unit_pkg;

   localparam int DIV_DATA_W = 32;

   typedef enum logic [2:0] {
      DIV_IDLE = 3'd0,
      DIV_PREP = 3'd1,
      DIV_DIV  = 3'd2,
      DIV_FIX  = 3'd3,
      DIV_DONE = 3'd4
   } div_state_e;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   // Cycles from the accept edge to the result_ok cycle.
   function automatic int div_lat(input int data_w);
      return data_w + 3;
   endfunction

   function automatic logic exe_is_div(input logic [7:0] aluop);
      return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
   endfunction

   function automatic logic exe_div_signed(input logic [7:0] aluop);
      return aluop == EXE_DIV_OP;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Start/result_ok handshake between the EX stage (master) and the divider (slave).
// start is held by EX until it sees the one-cycle result_ok pulse; operands are
// only sampled on the edge where the divider is idle and start=1, flush=0.
interface div_unit_if #(
   parameter int DATA_W = 32
);
   logic                  start;
   logic                  is_signed;
   logic                  flush;
   logic [DATA_W-1:0]     dividend;
   logic [DATA_W-1:0]     divisor;
   logic                  busy;
   logic                  result_ok;
   logic [2*DATA_W-1:0]   result;

   modport master (
      output start, is_signed, flush, dividend, divisor,
      input  busy, result_ok, result
   );

   modport slave (
      input  start, is_signed, flush, dividend, divisor,
      output busy, result_ok, result
   );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract the
// divisor, keep the difference when it did not borrow.
module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem_i,
   input  logic [DATA_W-1:0] quot_i,
   input  logic [DATA_W-1:0] divisor_i,
   output logic [DATA_W-1:0] rem_o,
   output logic [DATA_W-1:0] quot_o
);

   logic [DATA_W:0]   shifted;
   logic [DATA_W+1:0] trial;
   logic              borrow;

   // The shifted remainder can reach 2*divisor-1, so it needs one extra bit;
   // one more bit on the trial difference exposes the borrow.
   always_comb begin
      shifted = {rem_i, quot_i[DATA_W-1]};
      trial   = {1'b0, shifted} - {2'b00, divisor_i};
      borrow  = trial[DATA_W+1];
      rem_o   = borrow ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
      quot_o  = {quot_i[DATA_W-2:0], ~borrow};
   end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage. Produces {remainder, quotient}
// for hi/lo with a one-cycle result_ok pulse DATA_W+3 cycles after accept.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   div_unit_if.slave    bus,
   output div_state_e   state_o
);

   localparam int CNT_W = $clog2(DATA_W);

   div_state_e            state_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  signed_q;
   logic                  q_neg_q;
   logic                  r_neg_q;
   logic [DATA_W-1:0]     dvd_q;
   logic [DATA_W-1:0]     dvs_q;
   logic [DATA_W-1:0]     rem_q;
   logic [DATA_W-1:0]     quot_q;
   logic [2*DATA_W-1:0]   result_q;
   logic                  busy_q;
   logic                  result_ok_q;

   logic [DATA_W-1:0]     rem_d;
   logic [DATA_W-1:0]     quot_d;
   logic [DATA_W-1:0]     dvd_abs;
   logic [DATA_W-1:0]     dvs_abs;
   logic [DATA_W-1:0]     rem_fix;
   logic [DATA_W-1:0]     quot_fix;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem_i     (rem_q),
      .quot_i    (quot_q),
      .divisor_i (dvs_q),
      .rem_o     (rem_d),
      .quot_o    (quot_d)
   );

   always_comb begin
      dvd_abs  = (signed_q && dvd_q[DATA_W-1]) ? ('0 - dvd_q) : dvd_q;
      dvs_abs  = (signed_q && dvs_q[DATA_W-1]) ? ('0 - dvs_q) : dvs_q;
      rem_fix  = r_neg_q ? ('0 - rem_q)  : rem_q;
      quot_fix = q_neg_q ? ('0 - quot_q) : quot_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         signed_q    <= 1'b0;
         q_neg_q     <= 1'b0;
         r_neg_q     <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         quot_q      <= '0;
         result_q    <= '0;
         busy_q      <= 1'b0;
         result_ok_q <= 1'b0;
      end else begin
         result_ok_q <= 1'b0;
         if (bus.flush) begin
            // Cancel wins over everything, including a start in IDLE.
            state_q <= DIV_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               DIV_IDLE: begin
                  if (bus.start) begin
                     state_q  <= DIV_PREP;
                     busy_q   <= 1'b1;
                     signed_q <= bus.is_signed;
                     dvd_q    <= bus.dividend;
                     dvs_q    <= bus.divisor;
                  end
               end
               DIV_PREP: begin
                  if (dvs_q == '0) begin
                     // Divide by zero: all-ones quotient, untouched dividend as remainder.
                     state_q     <= DIV_DONE;
                     busy_q      <= 1'b0;
                     result_ok_q <= 1'b1;
                     result_q    <= {dvd_q, {DATA_W{1'b1}}};
                  end else begin
                     state_q <= DIV_DIV;
                     q_neg_q <= signed_q & (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1]);
                     r_neg_q <= signed_q & dvd_q[DATA_W-1];
                     dvs_q   <= dvs_abs;
                     quot_q  <= dvd_abs;
                     rem_q   <= '0;
                     cnt_q   <= CNT_W'(DATA_W - 1);
                  end
               end
               DIV_DIV: begin
                  rem_q  <= rem_d;
                  quot_q <= quot_d;
                  cnt_q  <= cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     state_q <= DIV_FIX;
                  end
               end
               DIV_FIX: begin
                  state_q     <= DIV_DONE;
                  busy_q      <= 1'b0;
                  result_ok_q <= 1'b1;
                  result_q    <= {rem_fix, quot_fix};
               end
               DIV_DONE: begin
                  state_q <= DIV_IDLE;
               end
               default: begin
                  state_q <= DIV_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.result_ok = result_ok_q;
   assign bus.result    = result_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, flush and reset cancel, and back-to-back throughput.
module tb_div_unit;
   import div_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   div_state_e state;
   int         checks = 0;
   int         errors = 0;

   div_unit_if #(.DATA_W(32)) bus ();

   div_unit #(.DATA_W(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .state_o (state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents start in the current cycle; the next edge is edge 0.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        input logic [63:0] exp_res, input int exp_cyc, input string tag);
      int ok_cnt;
      int ok_cyc;
      int busy_err;
      bus.start     = 1'b1;
      bus.is_signed = sg;
      bus.dividend  = a;
      bus.divisor   = b;
      step();
      bus.start     = 1'b0;
      bus.is_signed = ~sg;
      bus.dividend  = $urandom;
      bus.divisor   = $urandom;
      ok_cnt   = 0;
      ok_cyc   = 0;
      busy_err = 0;
      for (int c = 1; c <= exp_cyc + 2; c++) begin
         if (bus.result_ok) begin
            ok_cnt++;
            ok_cyc = c;
         end
         if (bus.busy !== (c < exp_cyc)) busy_err++;
         step();
      end
      chk({tag, "_ok_count"}, 64'(ok_cnt), 64'd1);
      chk({tag, "_ok_cycle"}, 64'(ok_cyc), 64'(exp_cyc));
      chk({tag, "_busy_errs"}, 64'(busy_err), 64'd0);
      chk({tag, "_result"}, bus.result, exp_res);
      chk({tag, "_idle"}, 64'(state), 64'(DIV_IDLE));
   endtask

   initial begin
      int ok_cnt;
      int ok_cyc;
      rst           = 1'b0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.flush     = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      repeat (3) step();
      chk("rst_result", bus.result, 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_ok", 64'(bus.result_ok), 64'd0);
      chk("rst_state", 64'(state), 64'(DIV_IDLE));
      rst = 1'b1;
      step();

      do_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 35, "divu_100_7");
      do_op(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 35, "div_m7_2");
      do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 35, "div_ovf");
      do_op(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, 35, "divu_max_1");
      do_op(32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF, 2, "div_by_zero");

      // Flush in cycle 10: nothing completes, previous result stays.
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd50; bus.divisor = 32'd5;
      step();
      bus.start = 1'b0;
      repeat (9) step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("flush_busy", 64'(bus.busy), 64'd0);
      chk("flush_state", 64'(state), 64'(DIV_IDLE));
      ok_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.result_ok) ok_cnt++;
         step();
      end
      chk("flush_no_ok", 64'(ok_cnt), 64'd0);
      chk("flush_result_kept", bus.result, 64'h00000005_FFFFFFFF);

      // flush together with start in IDLE: not accepted.
      bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 32'd8; bus.divisor = 32'd2;
      step();
      bus.start = 1'b0; bus.flush = 1'b0;
      chk("flush_start_state", 64'(state), 64'(DIV_IDLE));
      chk("flush_start_busy", 64'(bus.busy), 64'd0);

      // Reset in cycle 20, then a fresh op the following cycle.
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd10;
      step();
      bus.start = 1'b0;
      repeat (19) step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("midrst_result", bus.result, 64'd0);
      chk("midrst_state", 64'(state), 64'(DIV_IDLE));
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      do_op(32'd1000, 32'd10, 1'b0, 64'h00000000_00000064, 35, "after_rst");

      // Back-to-back with start held through DONE; 36-cycle throughput puts
      // the second DONE at cycle 71 after the first accept edge.
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      step();
      repeat (34) step();
      chk("b2b_first_ok", 64'(bus.result_ok), 64'd1);
      chk("b2b_first_state", 64'(state), 64'(DIV_DONE));
      bus.dividend = 32'd9; bus.divisor = 32'd3;
      step();
      chk("b2b_no_dup_accept", 64'(state), 64'(DIV_IDLE));
      chk("b2b_first_result", bus.result, 64'h00000002_0000000E);
      step();
      bus.start = 1'b0;
      chk("b2b_second_accept", 64'(state), 64'(DIV_PREP));
      ok_cnt = 0;
      ok_cyc = 0;
      for (int c = 37; c <= 75; c++) begin
         if (bus.result_ok) begin
            ok_cnt++;
            ok_cyc = c;
         end
         step();
      end
      chk("b2b_second_ok_count", 64'(ok_cnt), 64'd1);
      chk("b2b_second_ok_cycle", 64'(ok_cyc), 64'd71);
      chk("b2b_second_result", bus.result, 64'h00000000_00000003);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
